encode18_5_beta: RTL and testbench
==================================

// Module: encode18_5_beta
// PURPOSE
//  Thermometer-to-binary encoder for the 18-element Beta unit-element array; inverse of the 5->18 Beta decoder.
//  Converts the 18-bit element-enable word read back from the DAC element bank into a 5-bit Beta count (0..18).
//  Flags bubble (non-contiguous) codes and keeps a saturating error count for the monitor path.
//  Two-stage valid/ready pipeline between the element-readback register and the DSP checker.
// PARAMETERS
//  N_ELEM     18  number of thermometer elements
//  W_OUT      5   output code width; must satisfy 2**W_OUT > N_ELEM
//  ERR_CNT_W  8   width of the saturating bubble-error counter
// PORTS
//  clk         in   1       system clock, rising edge
//  rst         in   1       asynchronous reset, active-high
//  therm_in    in   18      thermometer word; bit0 is the first element to turn on
//  in_valid    in   1       therm_in is valid this cycle
//  in_ready    out  1       encoder accepts therm_in this cycle
//  code_out    out  5       encoded Beta count, 0..18
//  out_valid   out  1       code_out/bubble_err are valid
//  out_ready   in   1       downstream consumes code_out this cycle
//  bubble_err  out  1       the word that produced code_out was not a legal thermometer code
//  err_count   out  8       saturating count of bubble words accepted
//  err_clr     in   1       synchronous clear of err_count
// BEHAVIOUR
//  - One clock. Reset is asynchronous, active-high. On rst: both stage valids=0, code_out=0, bubble_err=0, err_count=0.
//  - Transfer at a port happens when valid&&ready. Stage S1 registers therm_in and the bubble flag.
//    Stage S2 registers code_out and bubble_err.
//  - Latency: 2 clk from input accept to out_valid, with no stalls. Throughput is 1 word/clk.
//  - Stall: S2 loads when !out_valid || out_ready. S1 loads when S2 loads or S1 is empty.
//    in_ready = !s1_valid || s2_load. in_ready is combinational from out_ready; there is no skid buffer.
//  - While out_valid && !out_ready: code_out and bubble_err stay stable.
//  - A word is legal iff it equals (1<<k)-1 for k in 0..18. bubble = !legal, computed on the raw therm_in.
//  - Encoding: code_out = k for legal words. 0 maps to 0 and all-ones maps to 18 (5'b10010).
//    Bubble handling depends on BUBBLE_CORR_EN (see CONFIGURATION).
//  - err_count: increments by 1 when a bubble word is accepted into S1. It saturates at 2**ERR_CNT_W-1.
//    If err_clr and a bubble accept occur in the same cycle, the result is err_count=1 (clear first, then count).
//  - rst asserted mid-stream: in-flight words are discarded. After rst deasserts, out_valid stays 0 until a new word has been accepted and has aged 2 clk.
// CONFIGURATION
//  BUBBLE_CORR_EN defined:
//    - Each bit is replaced by a 3-tap majority: t'[i] = maj(t[i-1], t[i], t[i+1]), with t[-1]=1 and t[N_ELEM]=0.
//    - code_out = popcount(t') clamped to 18.
//    - bubble_err still reports the raw, uncorrected word.
//  BUBBLE_CORR_EN undefined:
//    - code_out = index of the highest set bit + 1, or 0 if the word is all zeros.
//    - There is no correction.
// STRUCTURE
//  Shared package dac_beta_pkg:
//    - N_ELEM_BETA=18 and W_BETA=5.
//    - Thermometer word type therm18_t and code type beta_code_t.
//    - The constant BETA_MAX=18, shared with the 5->18 decoder.
//  Sub-module therm_bubble_chk: combinational legality check over N_ELEM bits.
//    Outputs legal and msb_idx; instantiated in S1.
//  Encode, majority filter and counter live in the top module.
// TESTING
//  - Sweep k=0..18: legal words (1<<k)-1, out_ready=1 -> code_out=k 2 clk later, bubble_err=0, err_count=0.
//  - therm_in=18'h0000B (0b1011), corr off -> code_out=4, bubble_err=1, err_count=1.
//    Same word with corr on -> code_out=3, bubble_err=1.
//  - out_ready=0 for 5 clk with 3 words queued -> in_ready drops after 2 accepts, code_out stays held.
//    Release -> codes arrive in order with none lost or duplicated.
//  - Drive 300 bubble words -> err_count saturates at 255.
//    err_clr on the same cycle as a bubble accept -> err_count=1.
//  - Assert rst while out_valid=1 -> out_valid=0, code_out=0, err_count=0 immediately (async).
//    The first post-reset word appears exactly 2 clk after its accept.

Source files
------------

// File: rtl/dac_beta_pkg.sv
// Shared Beta-array definitions used by the 5->18 decoder and the 18->5 encoder.
package dac_beta_pkg;

  localparam int N_ELEM_BETA = 18;
  localparam int W_BETA      = 5;
  localparam int BETA_MAX    = 18;

  typedef logic [N_ELEM_BETA-1:0] therm18_t;
  typedef logic [W_BETA-1:0]      beta_code_t;

endpackage

// File: rtl/encode18_5_beta_therm_bubble_chk.sv
// Combinational thermometer legality check.
// A word is legal when it has the form (1<<k)-1, which is the same as
// "adding one clears every set bit": (t & (t+1)) == 0. The 18-bit wrap
// of all-ones + 1 = 0 makes the full-scale word legal as well.
// msb_idx is one-based: position of the highest set bit + 1, or 0 for an all-zero word.
module therm_bubble_chk
  import dac_beta_pkg::*;
#(
  parameter int N = N_ELEM_BETA,
  parameter int W = W_BETA
) (
  input  logic [N-1:0] therm,
  output logic         legal,
  output logic [W-1:0] msb_idx
);

  logic [N-1:0] plus_one;

  assign plus_one = therm + N'(1);
  assign legal    = ((therm & plus_one) == '0);

  // Priority scan: later (higher) set bits overwrite earlier ones.
  always_comb begin
    msb_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (therm[i]) msb_idx = W'(i + 1);
    end
  end

endmodule

// File: rtl/encode18_5_beta.sv
// Thermometer-to-binary encoder for the 18-element Beta array.
// Optional feature macro: BUBBLE_CORR_EN (3-tap majority bubble correction).
//
// Handshake: a transfer happens on a port in any cycle where valid && ready
// are both high. S2 loads when it is empty or its word is being consumed;
// S1 loads when S2 loads or S1 is empty. in_ready is combinational from
// out_ready (no skid buffer). A stalled output holds code_out/bubble_err.
module encode18_5_beta
  import dac_beta_pkg::*;
#(
  parameter int N_ELEM    = N_ELEM_BETA,
  parameter int W_OUT     = W_BETA,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_ELEM-1:0]    therm_in,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [W_OUT-1:0]     code_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 bubble_err,
  output logic [ERR_CNT_W-1:0] err_count,
  input  logic                 err_clr
);

  localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

  logic             s1_valid;
  logic             s1_bubble;
  logic             s1_load;
  logic             s2_load;
  logic             accept;
  logic             chk_legal;
  logic [W_OUT-1:0] chk_msb;
  logic [W_OUT-1:0] enc_code;

  therm_bubble_chk #(
    .N (N_ELEM),
    .W (W_OUT)
  ) u_chk (
    .therm   (therm_in),
    .legal   (chk_legal),
    .msb_idx (chk_msb)
  );

  assign s2_load  = !out_valid || out_ready;
  assign s1_load  = !s1_valid || s2_load;
  assign in_ready = s1_load;
  assign accept   = in_valid && in_ready;

`ifdef BUBBLE_CORR_EN
  // S1 keeps the raw word; the majority filter runs between S1 and S2.
  logic [N_ELEM-1:0] s1_therm;
  logic [N_ELEM+1:0] ext;
  logic [W_OUT-1:0]  pop;
  logic              maj;

  // S1 payload register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  s1_therm <= '0;
    else if (s1_load && accept) s1_therm <= therm_in;
  end

  // Majority filter with the lower boundary tied on and the upper tied off,
  // then population count clamped to full scale.
  always_comb begin
    ext = {1'b0, s1_therm, 1'b1};
    pop = '0;
    maj = 1'b0;
    for (int i = 0; i < N_ELEM; i++) begin
      maj = (ext[i] & ext[i+1]) | (ext[i] & ext[i+2]) | (ext[i+1] & ext[i+2]);
      pop = pop + W_OUT'(maj);
    end
    enc_code = (pop > W_OUT'(N_ELEM)) ? W_OUT'(N_ELEM) : pop;
  end
`else
  // Without correction only the highest set bit matters, so S1 keeps that.
  logic [W_OUT-1:0] s1_msb;

  // S1 payload register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  s1_msb <= '0;
    else if (s1_load && accept) s1_msb <= chk_msb;
  end

  // Highest-set-bit encoding, already one-based from the checker.
  always_comb begin
    enc_code = s1_msb;
  end
`endif

  // S1 valid and raw bubble flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_bubble <= 1'b0;
    end else if (s1_load) begin
      s1_valid <= in_valid;
      if (accept) s1_bubble <= !chk_legal;
    end
  end

  // S2 output register; holds while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      code_out   <= '0;
      bubble_err <= 1'b0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        code_out   <= enc_code;
        bubble_err <= s1_bubble;
      end
    end
  end

  // Saturating bubble counter; clear takes effect before the same-cycle count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count <= '0;
    end else if (err_clr) begin
      err_count <= (accept && !chk_legal) ? ERR_CNT_W'(1) : '0;
    end else if (accept && !chk_legal && (err_count != ERR_MAX)) begin
      err_count <= err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_encode18_5_beta.sv
// Directed bench for encode18_5_beta: vector table streamed through a
// scoreboard, plus hand-written stall, saturation, clear and reset sequences.
module tb_encode18_5_beta;

  logic        clk = 1'b0;
  logic        rst;
  logic [17:0] therm_in;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  code_out;
  logic        out_valid;
  logic        out_ready;
  logic        bubble_err;
  logic [7:0]  err_count;
  logic        err_clr;

  encode18_5_beta dut (
    .clk        (clk),
    .rst        (rst),
    .therm_in   (therm_in),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .code_out   (code_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .bubble_err (bubble_err),
    .err_count  (err_count),
    .err_clr    (err_clr)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- vector records ----------------
  typedef struct {
    logic [17:0] therm;
    logic [4:0]  code;
    logic        bub;
  } vec_t;

  vec_t vecs[$];

  // pending input entries: {bubble, code, therm}
  logic [23:0] pend_q[$];
  // scoreboard: {bubble, code}
  logic [5:0]  exp_q[$];
  logic [7:0]  exp_err = 8'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] pack(input vec_t v);
    return {v.bub, v.code, v.therm};
  endfunction

  task automatic drive_next();
    in_valid = (pend_q.size() != 0);
    therm_in = in_valid ? pend_q[0][17:0] : 18'h0;
  endtask

  // One clock: score outputs at negedge, account accepts at posedge.
  task automatic step();
    logic       irdy;
    logic [5:0] e6;
    logic [23:0] e;
    @(negedge clk);
    irdy = in_ready;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", {26'h0, bubble_err, code_out}, 32'hffff_ffff);
      end else begin
        e6 = exp_q.pop_front();
        check("out_code", code_out, e6[4:0]);
        check("out_bubble", bubble_err, e6[5]);
      end
    end
    @(posedge clk);
    if (in_valid && irdy) begin
      e = pend_q.pop_front();
      exp_q.push_back(e[23:18]);
      if (err_clr) exp_err = e[23] ? 8'd1 : 8'd0;
      else if (e[23] && exp_err != 8'hff) exp_err = exp_err + 8'd1;
    end
    #1;
    drive_next();
  endtask

  task automatic drain(input int max_cycles);
    int n = 0;
    drive_next();
    while ((pend_q.size() != 0 || exp_q.size() != 0) && n < max_cycles) begin
      step();
      n++;
    end
    step();
    step();
    check("drain_left", pend_q.size() + exp_q.size(), 0);
  endtask

  // Accept at one edge, out_valid visible two cycles after the accept cycle.
  task automatic latency_check(input logic [17:0] t, input logic [4:0] c);
    out_ready = 1'b1;
    @(posedge clk); #1;
    therm_in = t;
    in_valid = 1'b1;
    @(negedge clk);
    check("lat_in_ready", in_ready, 1);
    check("lat_out_valid_0", out_valid, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("lat_out_valid_1", out_valid, 0);
    @(negedge clk);
    check("lat_out_valid_2", out_valid, 1);
    check("lat_code", code_out, c);
    check("lat_bubble", bubble_err, 0);
    @(posedge clk); #1;
  endtask

  vec_t v;

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    therm_in = 18'h0;
    out_ready = 1'b1;
    err_clr = 1'b0;

    // ---- vector table: legal sweep then bubble words ----
    for (int k = 0; k <= 18; k++) begin
      v.therm = 18'((64'd1 << k) - 64'd1);
      v.code  = 5'(k);
      v.bub   = 1'b0;
      vecs.push_back(v);
    end
`ifdef BUBBLE_CORR_EN
    vecs.push_back('{18'h0000B, 5'd3,  1'b1});
    vecs.push_back('{18'h3FFFE, 5'd18, 1'b1});
    vecs.push_back('{18'h20000, 5'd0,  1'b1});
    vecs.push_back('{18'h00005, 5'd2,  1'b1});
    vecs.push_back('{18'h00100, 5'd0,  1'b1});
`else
    vecs.push_back('{18'h0000B, 5'd4,  1'b1});
    vecs.push_back('{18'h3FFFE, 5'd18, 1'b1});
    vecs.push_back('{18'h20000, 5'd18, 1'b1});
    vecs.push_back('{18'h00005, 5'd3,  1'b1});
    vecs.push_back('{18'h00100, 5'd9,  1'b1});
`endif

    // ---- reset state ----
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_code", code_out, 0);
    check("rst_bubble", bubble_err, 0);
    check("rst_err_count", err_count, 0);
    rst = 1'b0;

    latency_check(18'h00003, 5'd2);

    // ---- legal sweep streamed back-to-back ----
    for (int i = 0; i <= 18; i++) pend_q.push_back(pack(vecs[i]));
    drain(100);
    check("sweep_err_count", err_count, 0);

    // ---- bubble words ----
    for (int i = 19; i < vecs.size(); i++) pend_q.push_back(pack(vecs[i]));
    drain(100);
    check("bubble_err_count", err_count, 5);

    // ---- stall: 3 words queued, output blocked for 5 clocks ----
    out_ready = 1'b0;
    pend_q.push_back({1'b0, 5'd3, 18'h00007});
    pend_q.push_back(pack(vecs[19]));
    pend_q.push_back({1'b0, 5'd18, 18'h3FFFF});
    drive_next();
    step();
    step();
    check("stall_accepts", pend_q.size(), 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_in_ready", in_ready, 0);
      check("stall_out_valid", out_valid, 1);
      check("stall_code_hold", code_out, 3);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    drain(50);
    check("stall_err_count", err_count, 6);

    // ---- saturation: 300 bubble words ----
    for (int i = 0; i < 300; i++) pend_q.push_back(pack(vecs[19]));
    drain(400);
    check("sat_err_count", err_count, 255);
    check("sat_model", err_count, exp_err);

    // ---- clear coinciding with a bubble accept ----
    pend_q.push_back(pack(vecs[20]));
    drive_next();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    @(negedge clk);
    check("clr_with_bubble", err_count, 1);
    @(posedge clk); #1;
    drain(20);
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    exp_err = 8'd0;
    @(negedge clk);
    check("clr_alone", err_count, 0);
    @(posedge clk); #1;

    // ---- asynchronous reset with data in flight ----
    pend_q.push_back(pack(vecs[22]));
    pend_q.push_back({1'b0, 5'd5, 18'h0001F});
    pend_q.push_back({1'b0, 5'd6, 18'h0003F});
    pend_q.push_back({1'b0, 5'd7, 18'h0007F});
    drive_next();
    out_ready = 1'b0;
    step();
    step();
    step();
    #2;
    check("pre_rst_valid", out_valid, 1);
    check("pre_rst_err", err_count, 1);
    rst = 1'b1;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_code", code_out, 0);
    check("async_rst_err", err_count, 0);
    check("async_rst_bubble", bubble_err, 0);
    pend_q.delete();
    exp_q.delete();
    exp_err = 8'd0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_idle", out_valid, 0);
    latency_check(18'h0007F, 5'd7);
    @(negedge clk);
    check("post_rst_consumed", out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
